// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the icache and the dcache, granting whole
// cache-line bursts round-robin and steering read beats back to the burst owner.
module mem_arbiter #(
    parameter int AW    = 12,
    parameter int DW    = 128,
    parameter int BEATS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_req_valid,
    output logic          ic_req_ready,
    input  logic [AW-1:0] ic_req_addr,
    output logic          ic_rsp_valid,
    output logic [DW-1:0] ic_rsp_data,
    input  logic          dc_req_valid,
    output logic          dc_req_ready,
    input  logic [AW-1:0] dc_req_addr,
    input  logic [DW-1:0] dc_req_wdata,
    input  logic          dc_req_rtype,
    output logic          dc_rsp_valid,
    output logic [DW-1:0] dc_rsp_data,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_req_addr,
    output logic          mem_req_we,
    output logic [DW-1:0] mem_req_wdata,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rsp_data,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] BEATS_C = CW'(BEATS);
    localparam logic [CW-1:0] LAST_C  = CW'(BEATS - 1);

    typedef enum logic {
        DMEM_READ  = 1'b0,
        DMEM_WRITE = 1'b1
    } dmem_rtype_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IC    = 2'd1,
        ARB_DC_RD = 2'd2,
        ARB_DC_WR = 2'd3
    } arb_state_t;

    arb_state_t    state_q, state_d;
    // rr_q == 0 favours the dcache on contention, 1 favours the icache
    logic          rr_q, rr_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
    logic          err_q, err_d;

    logic          owner_valid_s;
    logic          read_state_s;
    logic          req_open_s;
    logic          req_hs_s;
    logic          rsp_accept_s;
    logic          err_set_s;

    assign busy        = (state_q != ARB_IDLE);
    assign err         = err_q;
    assign ic_rsp_data = mem_rsp_data;
    assign dc_rsp_data = mem_rsp_data;
    assign req_open_s  = (req_cnt_q < BEATS_C);

    // Owner mux: selects which requester drives the memory request fields.
    always_comb begin
        owner_valid_s = 1'b0;
        read_state_s  = 1'b0;
        mem_req_addr  = {AW{1'b0}};
        mem_req_we    = 1'b0;
        mem_req_wdata = {DW{1'b0}};
        case (state_q)
            ARB_IC: begin
                owner_valid_s = ic_req_valid;
                read_state_s  = 1'b1;
                mem_req_addr  = ic_req_addr;
            end
            ARB_DC_RD: begin
                owner_valid_s = dc_req_valid;
                read_state_s  = 1'b1;
                mem_req_addr  = dc_req_addr;
                mem_req_wdata = dc_req_wdata;
            end
            ARB_DC_WR: begin
                owner_valid_s = dc_req_valid;
                mem_req_addr  = dc_req_addr;
                mem_req_wdata = dc_req_wdata;
                mem_req_we    = 1'b1;
            end
            default: begin
                owner_valid_s = 1'b0;
            end
        endcase
    end

    // Handshake and response steering; nothing here adds a cycle of latency.
    always_comb begin
        mem_req_valid = owner_valid_s & req_open_s;
        req_hs_s      = mem_req_valid & mem_req_ready;
        ic_req_ready  = (state_q == ARB_IC) & mem_req_ready & req_open_s;
        dc_req_ready  = ((state_q == ARB_DC_RD) | (state_q == ARB_DC_WR))
                        & mem_req_ready & req_open_s;
        // Beats past BEATS, or with no read owner, are dropped and flagged
        rsp_accept_s  = mem_rsp_valid & read_state_s & (rsp_cnt_q < BEATS_C);
        ic_rsp_valid  = rsp_accept_s & (state_q == ARB_IC);
        dc_rsp_valid  = rsp_accept_s & (state_q == ARB_DC_RD);
        err_set_s     = mem_rsp_valid & ~rsp_accept_s;
    end

    // Next-state: grant from IDLE, hold the grant until the burst is complete.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        req_cnt_d = req_cnt_q + {{(CW-1){1'b0}}, req_hs_s};
        rsp_cnt_d = rsp_cnt_q + {{(CW-1){1'b0}}, rsp_accept_s};
        err_d     = err_q | err_set_s;
        case (state_q)
            ARB_IDLE: begin
                req_cnt_d = {CW{1'b0}};
                rsp_cnt_d = {CW{1'b0}};
                if (dc_req_valid && (!ic_req_valid || !rr_q)) begin
                    state_d = (dc_req_rtype == DMEM_WRITE) ? ARB_DC_WR : ARB_DC_RD;
                    rr_d    = 1'b1;
                end else if (ic_req_valid) begin
                    state_d = ARB_IC;
                    rr_d    = 1'b0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_IC, ARB_DC_RD: begin
                if ((req_cnt_d == BEATS_C) && (rsp_cnt_d == BEATS_C)) begin
                    state_d   = ARB_IDLE;
                    req_cnt_d = {CW{1'b0}};
                    rsp_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ARB_DC_WR: begin
                if (req_hs_s && (req_cnt_q == LAST_C)) begin
                    state_d   = ARB_IDLE;
                    req_cnt_d = {CW{1'b0}};
                    rsp_cnt_d = {CW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                req_cnt_d = {CW{1'b0}};
                rsp_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // State, pointer, counters and sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            rr_q      <= 1'b0;
            req_cnt_q <= {CW{1'b0}};
            rsp_cnt_q <= {CW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected memory beats
// and response data; a memory model answers reads and a negedge monitor compares.
module tb_mem_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 128;
    localparam int BEATS = 4;
    localparam logic [DW-1:0] STRAY = {4{32'hDEAD_BEEF}};

    logic          clk = 1'b0;
    logic          rst;
    logic          ic_req_valid, ic_req_ready, ic_rsp_valid;
    logic [AW-1:0] ic_req_addr;
    logic [DW-1:0] ic_rsp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rtype, dc_rsp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_wdata, dc_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_rsp_data;
    logic          busy, err;

    mem_arbiter #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_rtype(dc_req_rtype),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } beat_t;
    typedef struct { int due; logic [AW-1:0] addr; } pend_t;

    beat_t         mem_exp[$];
    logic [DW-1:0] ic_exp[$];
    logic [DW-1:0] dc_exp[$];
    pend_t         rsp_q[$];

    int n_checks    = 0;
    int n_fail      = 0;
    int hs_total    = 0;
    int stall_at    = -1;
    int stall_left  = 0;
    int stall_len   = 3;
    int rdy_mode    = 0;
    int inj_n       = 0;
    int ic_rsp_seen = 0;
    bit silent      = 1'b0;

    function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a);
        return {4{20'hD00D0, a}};
    endfunction

    function automatic logic [DW-1:0] wr_data(input logic [AW-1:0] a);
        return {4{20'h5EED0, a}};
    endfunction

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_burst(input logic [AW-1:0] base, input bit we, input bit from_dc);
        beat_t b;
        for (int i = 0; i < BEATS; i++) begin
            b.addr  = base + AW'(i);
            b.we    = we;
            b.wdata = from_dc ? wr_data(base + AW'(i)) : {DW{1'b0}};
            mem_exp.push_back(b);
        end
    endtask

    task automatic ic_burst(input logic [AW-1:0] base, input bit push_rsp,
                            output int first_acc, output int last_acc);
        int waited;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < BEATS; i++) begin
            if (push_rsp) ic_exp.push_back(rd_data(base + AW'(i)));
            ic_req_valid = 1'b1;
            ic_req_addr  = base + AW'(i);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!ic_req_ready && waited < 64);
            if (!ic_req_ready) check_eq("ic_ready_timeout", DW'(ic_req_ready), DW'(1));
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
        end
        ic_req_valid = 1'b0;
    endtask

    task automatic dc_burst(input logic [AW-1:0] base, input bit wr,
                            output int first_acc, output int last_acc);
        int waited;
        first_acc = -1;
        last_acc  = -1;
        for (int i = 0; i < BEATS; i++) begin
            if (!wr) dc_exp.push_back(rd_data(base + AW'(i)));
            dc_req_valid = 1'b1;
            dc_req_rtype = wr;
            dc_req_addr  = base + AW'(i);
            dc_req_wdata = wr_data(base + AW'(i));
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!dc_req_ready && waited < 64);
            if (!dc_req_ready) check_eq("dc_ready_timeout", DW'(dc_req_ready), DW'(1));
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk); #1;
        end
        dc_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy && ic_exp.size() == 0 && dc_exp.size() == 0 &&
                   mem_exp.size() == 0 && rsp_q.size() == 0 && inj_n == 0;
        end
        check_eq("idle_drain", DW'(done), DW'(1));
        @(posedge clk); #1;
    endtask

    // Monitor: memory-bus beats and requester responses against the scoreboard.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req_valid && mem_req_ready) begin
                    if (mem_exp.size() > 0) begin
                        b = mem_exp.pop_front();
                        check_eq("mem_addr", DW'(mem_req_addr), DW'(b.addr));
                        check_eq("mem_we", DW'(mem_req_we), DW'(b.we));
                        check_eq("mem_wdata", mem_req_wdata, b.wdata);
                    end else begin
                        check_eq("mem_extra_beat", DW'(mem_exp.size()), DW'(1));
                    end
                    if (!mem_req_we && !silent) rsp_q.push_back('{cyc + 2, mem_req_addr});
                    if (hs_total == stall_at) stall_left = stall_len;
                    hs_total++;
                end
                if (ic_rsp_valid) begin
                    if (ic_exp.size() > 0) check_eq("ic_rsp_data", ic_rsp_data, ic_exp.pop_front());
                    else check_eq("ic_rsp_extra", DW'(ic_exp.size()), DW'(1));
                    ic_rsp_seen++;
                end
                if (dc_rsp_valid) begin
                    if (dc_exp.size() > 0) check_eq("dc_rsp_data", dc_rsp_data, dc_exp.pop_front());
                    else check_eq("dc_rsp_extra", DW'(dc_exp.size()), DW'(1));
                end
            end
        end
    end

    // Memory model: ready pattern, read responses two cycles after acceptance, stray beats.
    initial begin
        pend_t p;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = {DW{1'b0}};
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                rsp_q.delete();
                stall_left    = 0;
                mem_req_ready = 1'b1;
                mem_rsp_valid = 1'b0;
            end else begin
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                end else if (rdy_mode == 1) mem_req_ready = ~mem_req_ready;
                else mem_req_ready = 1'b1;
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    p = rsp_q.pop_front();
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rd_data(p.addr);
                end else if (inj_n > 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = STRAY;
                    inj_n--;
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = {DW{1'b0}};
                end
            end
        end
    end

    initial begin
        int st, fa, la, fd, ld, fi, li, seen0, waited;
        rst = 1'b1;
        ic_req_valid = 1'b0; ic_req_addr = '0;
        dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_wdata = '0; dc_req_rtype = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", DW'(busy), DW'(0));
        check_eq("rst_err", DW'(err), DW'(0));
        check_eq("rst_mem_valid", DW'(mem_req_valid), DW'(0));
        check_eq("rst_ic_ready", DW'(ic_req_ready), DW'(0));
        check_eq("rst_dc_ready", DW'(dc_req_ready), DW'(0));
        check_eq("rst_ic_rsp", DW'(ic_rsp_valid), DW'(0));
        check_eq("rst_dc_rsp", DW'(dc_rsp_valid), DW'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // IC read alone
        exp_burst(12'h010, 1'b0, 1'b0);
        st = cyc;
        ic_burst(12'h010, 1'b1, fa, la);
        check_eq("ic_grant_latency", DW'(fa), DW'(st + 1));
        check_eq("ic_ready_consecutive", DW'(la), DW'(fa + 3));
        @(negedge clk);
        check_eq("busy_rsp_pending", DW'(busy), DW'(1));
        @(negedge clk);
        check_eq("ic_last_rsp_cycle", DW'(ic_rsp_valid), DW'(1));
        @(negedge clk);
        check_eq("idle_after_last_rsp", DW'(busy), DW'(0));
        wait_idle();

        // contention twice: DC first each time
        for (int r = 0; r < 2; r++) begin
            exp_burst(12'h040 + AW'(16 * r), 1'b0, 1'b1);
            exp_burst(12'h020 + AW'(16 * r), 1'b0, 1'b0);
            fork
                dc_burst(12'h040 + AW'(16 * r), 1'b0, fd, ld);
                ic_burst(12'h020 + AW'(16 * r), 1'b1, fi, li);
            join
            check_eq("dc_before_ic", DW'(ld < fi), DW'(1));
            wait_idle();
        end

        // DC write with toggling ready, IC pending
        rdy_mode = 1;
        @(posedge clk); #1;
        exp_burst(12'h060, 1'b1, 1'b1);
        exp_burst(12'h070, 1'b0, 1'b0);
        fork
            begin
                dc_burst(12'h060, 1'b1, fd, ld);
                @(negedge clk);
                check_eq("wr_idle_after_last", DW'(busy), DW'(0));
                check_eq("wr_idle_no_valid", DW'(mem_req_valid), DW'(0));
                @(negedge clk);
                check_eq("ic_grant_after_wr", DW'(mem_req_valid), DW'(1));
                check_eq("ic_addr_after_wr", DW'(mem_req_addr), DW'(12'h070));
            end
            ic_burst(12'h070, 1'b1, fi, li);
        join
        rdy_mode = 0;
        wait_idle();

        // ready stall after beat 1; early responses
        stall_len = 3;
        stall_at  = hs_total + 1;
        seen0     = ic_rsp_seen;
        exp_burst(12'h080, 1'b0, 1'b0);
        ic_burst(12'h080, 1'b1, fa, la);
        check_eq("rsp_before_req_done", DW'(ic_rsp_seen - seen0), DW'(2));
        wait_idle();
        check_eq("stall_rsp_total", DW'(ic_rsp_seen - seen0), DW'(4));
        stall_at = -1;

        // fifth response beat inside a read burst
        check_eq("err_clear_before", DW'(err), DW'(0));
        stall_len = 8;
        stall_at  = hs_total + 1;
        seen0     = ic_rsp_seen;
        ic_exp.push_back(rd_data(12'h090));
        ic_exp.push_back(rd_data(12'h091));
        ic_exp.push_back(STRAY);
        ic_exp.push_back(STRAY);
        exp_burst(12'h090, 1'b0, 1'b0);
        fork
            ic_burst(12'h090, 1'b0, fa, la);
            begin
                waited = 0;
                do begin
                    @(negedge clk); #1;
                    waited++;
                end while (ic_rsp_seen < seen0 + 2 && waited < 40);
                inj_n  = 3;
                waited = 0;
                do begin
                    @(negedge clk); #1;
                    waited++;
                end while (!err && waited < 20);
                check_eq("err_on_5th_beat", DW'(err), DW'(1));
                check_eq("err_while_reading", DW'(busy), DW'(1));
            end
        join
        wait_idle();
        check_eq("err_sticky", DW'(err), DW'(1));
        stall_at  = -1;
        stall_len = 3;

        // async reset after two accepted beats
        silent = 1'b1;
        mem_exp.push_back('{12'h0A0, 1'b0, {DW{1'b0}}});
        mem_exp.push_back('{12'h0A1, 1'b0, {DW{1'b0}}});
        ic_req_valid = 1'b1;
        ic_req_addr  = 12'h0A0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ic_req_ready && waited < 20);
        @(posedge clk); #1;
        ic_req_addr = 12'h0A1;
        @(negedge clk);
        @(posedge clk); #1;
        ic_req_addr = 12'h0A2;
        check_eq("busy_before_rst", DW'(busy), DW'(1));
        check_eq("ready_before_rst", DW'(ic_req_ready), DW'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_ready", DW'(ic_req_ready), DW'(0));
        check_eq("rst_async_valid", DW'(mem_req_valid), DW'(0));
        check_eq("rst_async_busy", DW'(busy), DW'(0));
        check_eq("rst_async_err", DW'(err), DW'(0));
        ic_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        silent = 1'b0;
        check_eq("rst_beats_seen", DW'(mem_exp.size()), DW'(0));

        exp_burst(12'h0B0, 1'b0, 1'b0);
        st = cyc;
        ic_burst(12'h0B0, 1'b1, fa, la);
        check_eq("post_rst_latency", DW'(fa), DW'(st + 1));
        check_eq("post_rst_consecutive", DW'(la), DW'(fa + 3));
        wait_idle();

        // stray response beat while idle
        @(negedge clk);
        check_eq("err_clear_idle", DW'(err), DW'(0));
        inj_n  = 1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!err && waited < 6);
        check_eq("err_on_idle_beat", DW'(err), DW'(1));
        repeat (3) @(negedge clk);
        check_eq("err_stays", DW'(err), DW'(1));
        check_eq("idle_after_stray", DW'(busy), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single 128-bit main-memory port between the instruction cache (read-only line fills) and the data cache (line fills and dirty-line evictions). It grants the port for a whole cache-line burst of `BEATS` transfers, alternates round-robin under contention, and routes read-response beats back to the burst owner. It sits between the icache/dcache miss/evict controllers and the memory model/controller.

## Interface
- `AW`, default `MEM_ADDR_BUS` (12): memory beat address width.
- `DW`, default `MEM_DATA_BUS` (128): memory data width.
- `BEATS`, default `MEM_TRANSFERS_PER_CL` (4): transfers per cache line; power of 2, ≥2.

One clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `ic_req_valid` / `ic_req_ready`, in / out, 1: icache request beat handshake.
- `ic_req_addr` in AW: icache beat address.
- `ic_rsp_valid` out 1: icache response beat; `ic_rsp_data` out DW.
- `dc_req_valid` / `dc_req_ready`, in / out, 1: dcache request beat handshake.
- `dc_req_addr` in AW; `dc_req_wdata` in DW.
- `dc_req_rtype` in 1: `dmem_rtype_t` (`DMEM_READ`/`DMEM_WRITE`); stable while `dc_req_valid`.
- `dc_rsp_valid` out 1; `dc_rsp_data` out DW.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: memory request handshake.
- `mem_req_addr` out AW; `mem_req_we` out 1; `mem_req_wdata` out DW.
- `mem_rsp_valid` in 1; `mem_rsp_data` in DW: memory read beats, in order, no backpressure.
- `busy` out 1: state ≠ `ARB_IDLE`.
- `err` out 1: sticky, set on a response beat with no read owner; cleared only by reset.

## Operation
- States: `ARB_IDLE`, `ARB_IC`, `ARB_DC_RD`, `ARB_DC_WR`.
- `ARB_IDLE`: no ready asserted, `mem_req_valid`=0. If only one requester is valid, grant it; if both, grant per round-robin pointer `rr` (reset value: favour DC). DC grant goes to `ARB_DC_RD`/`ARB_DC_WR` from `dc_req_rtype` sampled that cycle. `rr` flips to favour the other requester on every grant.
- Owner states: `req_cnt` and `rsp_cnt` cleared on entry, width `$clog2(BEATS)+1`.
  - `mem_req_valid` = owner valid & (`req_cnt` < BEATS); owner ready = `mem_req_ready` & (`req_cnt` < BEATS); non-owner ready = 0.
  - `mem_req_addr`/`mem_req_wdata` driven from owner; `mem_req_we` = 1 only in `ARB_DC_WR`; `mem_req_wdata` = 0 when owner is IC.
  - `req_cnt` increments on each `mem_req_valid & mem_req_ready`.
  - Read states: each `mem_rsp_valid` increments `rsp_cnt` and asserts the owner's rsp_valid; rsp_data is combinational pass-through of `mem_rsp_data` to both requesters.
- Burst completion returns to `ARB_IDLE`:
  - Read: `req_cnt`==BEATS and `rsp_cnt`==BEATS, including the count increments of the current cycle.
  - Write: the BEATS-th request handshake.
- Addresses are forwarded unmodified; no alignment check.
- Owner may drop valid mid-burst; the grant stays locked until completion.
- Response beats may arrive before all request beats are accepted; the two counters are independent.
- `mem_rsp_valid` in `ARB_IDLE`/`ARB_DC_WR`, or beyond BEATS in a read state: beat dropped, no rsp_valid, `err` set.

## Timing
- Reset values: state `ARB_IDLE`, `rr` favours DC, counters 0, `err`=0. All valid/ready outputs and `busy` are 0; data outputs follow the combinational rules.
- Async reset mid-burst aborts immediately; the memory side is not drained.
- Arbitration latency is 1 cycle: request valid in cycle N (IDLE) gives owner ready no earlier than N+1.
- After completion there is 1 IDLE cycle before the next grant. Back-to-back bursts cost BEATS+1 request cycles minimum with `mem_req_ready` held high.
- Request and response paths are combinational (ready→ready, valid→valid, rsp→rsp) with zero added latency inside a grant.

## Test plan
- IC read alone, addresses 0x010–0x013, `mem_req_ready`=1, responses 2 cycles later with data A0–A3 -> `ic_req_ready` high 4 consecutive cycles from N+1, `mem_req_we`=0, `ic_rsp_valid` carries A0–A3, `dc_rsp_valid` never 1, IDLE one cycle after A3.
- Both valid from reset (DC read, IC read) -> DC served first, then IC. Both re-request -> DC again (pointer alternates). With only IC pending, IC granted regardless of pointer.
- DC write 4 beats, wdata W0–W3, `mem_req_ready` toggling 1-0-1-0 -> `mem_req_we`=1, W0–W3 forwarded in order, IDLE after 4th handshake, pending IC granted next cycle.
- Read, `mem_req_ready` stalls 3 cycles after beat 1, responses for beats 0–1 arrive before beat 2 is accepted -> completion only after 4 requests and 4 responses, no extra rsp_valid.
- `mem_rsp_valid` pulse in IDLE and a 5th response beat in a read -> `err` rises and stays 1, no rsp_valid.
- `rst` asserted asynchronously after 2 accepted beats -> ready/valid/busy drop without a clock edge. After release, a new IC burst completes all 4 beats with counts starting at 0.
